// File: rtl/bka_pkg.sv
// Shared types for the streaming Brent-Kung adder stage.
// Operand beats and sum beats travel through the pipeline as packed structs.
package bka_pkg;

  localparam int ADD_W = 10;

  typedef struct packed {
    logic [ADD_W-1:0] x;
    logic [ADD_W-1:0] y;
    logic             first;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [ADD_W-1:0] sum;
    logic             cout;
    logic             last;
  } sum_t;

endpackage

// File: rtl/UBPriBKA_9_0.sv
// 10-bit unsigned Brent-Kung prefix adder with carry-in.
// S[9:0] is the sum word and S[10] is the carry-out.
module UBPriBKA_9_0 (
  output logic [10:0] S,
  input  logic [9:0]  X,
  input  logic [9:0]  Y,
  input  logic        Cin
);

  function automatic logic [10:0] bk_add(input logic [9:0] a,
                                         input logic [9:0] b,
                                         input logic       cin);
    logic [9:0]  g;
    logic [9:0]  p;
    logic [9:0]  h;
    logic [10:0] c;
    h = a ^ b;
    g = a & b;
    p = h;
    // Folding cin into bit 0 makes every prefix G[i] the carry out of bit i.
    g[0] = g[0] | (p[0] & cin);
    for (int s = 1; s < 10; s = s * 2) begin
      for (int i = 0; i < 10; i++) begin
        if (((i + 1) % (2 * s)) == 0) begin
          g[i] = g[i] | (p[i] & g[i-s]);
          p[i] = p[i] & p[i-s];
        end
      end
    end
    for (int s = 4; s >= 1; s = s / 2) begin
      for (int i = 0; i < 10; i++) begin
        if ((i >= 2 * s) && (((i + 1) % (2 * s)) == s)) begin
          g[i] = g[i] | (p[i] & g[i-s]);
          p[i] = p[i] & p[i-s];
        end
      end
    end
    c = {g, cin};
    return {c[10], h ^ c[9:0]};
  endfunction

  always_comb begin
    S = bk_add(X, Y, Cin);
  end

endmodule

// File: rtl/bka_stream_adder.sv
// Streaming multi-word adder: skid register -> Brent-Kung adder -> output register,
// with the carry chained between beats of a packet through carry_q.
module bka_stream_adder
  import bka_pkg::beat_t;
  import bka_pkg::sum_t;
#(
  parameter int ADD_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADD_W-1:0] in_x,
  input  logic [ADD_W-1:0] in_y,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ADD_W-1:0] out_sum,
  output logic             out_cout,
  output logic             out_last,
  output logic             busy
);

  if (ADD_W != bka_pkg::ADD_W) begin : g_bad_width
    $error("bka_stream_adder: ADD_W must be 10 to match UBPriBKA_9_0");
  end

  beat_t          in_beat;
  beat_t          sel_beat;
  beat_t          skid_q;
  beat_t          skid_d;
  sum_t           out_q;
  sum_t           out_d;
  logic           skid_valid_q;
  logic           skid_valid_d;
  logic           out_valid_q;
  logic           out_valid_d;
  logic           in_ready_q;
  logic           in_ready_d;
  logic           carry_q;
  logic           carry_d;
  logic           busy_q;
  logic           busy_d;
  logic           in_fire;
  logic           out_can_load;
  logic           load_out;
  logic           add_cin;
  logic [ADD_W:0] add_s;

  always_comb begin
    in_beat.x     = in_x;
    in_beat.y     = in_y;
    in_beat.first = in_first;
    in_beat.last  = in_last;
    in_fire       = in_valid & in_ready_q;
    out_can_load  = ~out_valid_q | out_ready;
    // A waiting skid entry is older than anything on the input, so it goes first.
    sel_beat      = skid_valid_q ? skid_q : in_beat;
    load_out      = out_can_load & (skid_valid_q | in_fire);
    add_cin       = sel_beat.first ? 1'b0 : carry_q;
  end

  UBPriBKA_9_0 u_add (
    .S   (add_s),
    .X   (sel_beat.x),
    .Y   (sel_beat.y),
    .Cin (add_cin)
  );

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (out_can_load && skid_valid_q) begin
      skid_valid_d = in_fire;
      if (in_fire) begin
        skid_d = in_beat;
      end
    end else if (in_fire && !out_can_load) begin
      skid_valid_d = 1'b1;
      skid_d       = in_beat;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    out_d       = out_q;
    carry_d     = carry_q;
    // Carry commits when a beat enters the output register, which preserves order.
    if (load_out) begin
      out_valid_d = 1'b1;
      out_d.sum   = add_s[ADD_W-1:0];
      out_d.cout  = add_s[ADD_W];
      out_d.last  = sel_beat.last;
      carry_d     = sel_beat.last ? 1'b0 : add_s[ADD_W];
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (in_fire) begin
      if (in_last) begin
        busy_d = 1'b0;
      end else if (in_first) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      in_ready_q   <= 1'b1;
      carry_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      in_ready_q   <= in_ready_d;
      carry_q      <= carry_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    out_sum   = out_q.sum;
    out_cout  = out_q.cout;
    out_last  = out_q.last;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_bka_stream_adder.sv
// Self-checking bench for bka_stream_adder: table vectors, hand-written
// corner sequences and random packets, all checked through an expected-result queue.
module tb_bka_stream_adder;
  import bka_pkg::*;

  localparam int W = bka_pkg::ADD_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_last;
  logic         busy;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         first;
    logic         last;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  vec_t vecs[$];
  sum_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   accCount = 0;
  int   popCount = 0;
  int   cyc = 0;
  logic randReady = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  bka_stream_adder #(.ADD_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Handshakes are sampled mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin : monitor
    sum_t e;
    if (rst_n) begin
      if (in_valid && in_ready) accCount++;
      if (out_valid && out_ready) begin
        popCount++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output: got sum=%0d required no output", out_sum);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_sum", 32'(out_sum), 32'(e.sum));
          checkOutput("out_cout", 32'(out_cout), 32'(e.cout));
          checkOutput("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic first, input logic last,
                               input logic [W-1:0] esum, input logic ecout);
    sum_t s;
    logic accepted;
    accepted = 1'b0;
    in_x     = x;
    in_y     = y;
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    for (int w = 0; w < 50 && !accepted; w++) begin
      @(negedge clk);
      if (in_ready) begin
        s.sum  = esum;
        s.cout = ecout;
        s.last = last;
        expQ.push_back(s);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    checkOutput("beat_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic waitDrain();
    for (int w = 0; w < 40 && expQ.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic runRandom(input int packets);
    logic         mc;
    logic         cin;
    logic [W:0]   full;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           len;
    mc = 1'b0;
    for (int p = 0; p < packets; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        x    = W'($urandom_range(0, 1023));
        y    = W'($urandom_range(0, 1023));
        cin  = (b == 0) ? 1'b0 : mc;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        mc   = (b == len - 1) ? 1'b0 : full[W];
        applyStimulus(x, y, b == 0, b == len - 1, full[W-1:0], full[W]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int p0;
    int a0;

    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_out_cout", 32'(out_cout), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    vecs.push_back('{10'd1023, 10'd1,   1'b1, 1'b1, 10'd0,   1'b1});
    vecs.push_back('{10'd5,    10'd6,   1'b1, 1'b1, 10'd11,  1'b0});
    vecs.push_back('{10'd1023, 10'd1,   1'b1, 1'b0, 10'd0,   1'b1});
    vecs.push_back('{10'd0,    10'd0,   1'b0, 1'b1, 10'd1,   1'b0});
    vecs.push_back('{10'd512,  10'd512, 1'b1, 1'b0, 10'd0,   1'b1});
    vecs.push_back('{10'd512,  10'd512, 1'b0, 1'b0, 10'd1,   1'b1});
    vecs.push_back('{10'd512,  10'd512, 1'b0, 1'b0, 10'd1,   1'b1});
    vecs.push_back('{10'd512,  10'd512, 1'b0, 1'b1, 10'd1,   1'b1});
    vecs.push_back('{10'd1023, 10'd1,   1'b1, 1'b0, 10'd0,   1'b1});
    vecs.push_back('{10'd0,    10'd0,   1'b1, 1'b1, 10'd0,   1'b0});
    vecs.push_back('{10'd7,    10'd8,   1'b0, 1'b1, 10'd15,  1'b0});
    vecs.push_back('{10'd1000, 10'd1000,1'b1, 1'b0, 10'd976, 1'b1});
    vecs.push_back('{10'd1023, 10'd1023,1'b0, 1'b0, 10'd1023,1'b1});
    vecs.push_back('{10'd0,    10'd0,   1'b0, 1'b1, 10'd1,   1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].first, vecs[i].last,
                    vecs[i].esum, vecs[i].ecout);
    end
    waitDrain();

    // Two-beat packet: busy spans the gap between first and last.
    applyStimulus(10'd1023, 10'd1, 1'b1, 1'b0, 10'd0, 1'b1);
    checkOutput("busy_mid_packet", 32'(busy), 32'd1);
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 10'd1, 1'b0);
    checkOutput("busy_after_last", 32'(busy), 32'd0);
    waitDrain();

    t0 = cyc;
    p0 = popCount;
    for (int b = 0; b < 4; b++) begin
      applyStimulus(10'd512, 10'd512, b == 0, b == 3, (b == 0) ? 10'd0 : 10'd1, 1'b1);
    end
    checkOutput("tput_cycles", 32'(cyc - t0), 32'd4);
    waitDrain();
    checkOutput("tput_outputs", 32'(popCount - p0), 32'd4);

    // Backpressure: output register plus skid hold two beats, the third waits.
    out_ready = 1'b0;
    a0 = accCount;
    applyStimulus(10'd10, 10'd20, 1'b1, 1'b0, 10'd30, 1'b0);
    applyStimulus(10'd30, 10'd40, 1'b0, 1'b0, 10'd70, 1'b0);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_x     = 10'd50;
    in_y     = 10'd60;
    in_first = 1'b0;
    in_last  = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_accepted", 32'(accCount - a0), 32'd2);
    checkOutput("bp_in_ready_hold", 32'(in_ready), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_out_stable", 32'(out_sum), 32'd30);
    out_ready = 1'b1;
    applyStimulus(10'd50, 10'd60, 1'b0, 1'b1, 10'd110, 1'b0);
    waitDrain();

    // Reset mid-packet drops the buffered beat and the pending carry.
    out_ready = 1'b0;
    applyStimulus(10'd1023, 10'd1, 1'b1, 1'b0, 10'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_out_cout", 32'(out_cout), 32'd0);
    checkOutput("mid_rst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("mid_rst_out_last", 32'(out_last), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    expQ.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 10'd0, 1'b0);
    waitDrain();

    randReady = 1'b1;
    runRandom(15);
    randReady = 1'b0;
    out_ready = 1'b1;
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
